// File: rtl/gray_counter.sv
// Free-running reflected-binary Gray counter with enable and wrap-around flag.
// Define GRAY_STICKY_OVF_EN for a sticky Overflow; otherwise Overflow is a one-cycle pulse.
module gray_counter #(
  parameter int WIDTH = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  output logic [WIDTH-1:0] Output,
  output logic             Overflow
);

  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic             wrap;

  always_comb begin
    bin_next  = bin + WIDTH'(1);
    gray_next = bin_next ^ (bin_next >> 1);
    // The wrap from all-ones back to zero only counts when the step is enabled.
    wrap      = En && (bin == '1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bin      <= '0;
      Output   <= '0;
      Overflow <= 1'b0;
    end else begin
      if (En) begin
        bin    <= bin_next;
        Output <= gray_next;
      end
`ifdef GRAY_STICKY_OVF_EN
      if (wrap) Overflow <= 1'b1;
`else
      Overflow <= wrap;
`endif
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: WIDTH=3 and WIDTH=4 instances against a
// reflection-built Gray table model, plus directed literal expectations.
module tb_gray_counter;

  logic       Clk;
  logic       Reset;
  logic       En3;
  logic       En4;
  logic [2:0] out3;
  logic [3:0] out4;
  logic       ovf3;
  logic       ovf4;

  int checks = 0;
  int errors = 0;

  gray_counter #(.WIDTH(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .En(En3), .Output(out3), .Overflow(ovf3)
  );
  gray_counter #(.WIDTH(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .En(En4), .Output(out4), .Overflow(ovf4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Gray tables built by reflection: mirror the existing list and set the new top bit.
  int g3[8];
  int g4[16];
  initial begin
    int len;
    g3[0] = 0;
    len = 1;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < len; i++) g3[2*len-1-i] = g3[i] | (1 << b);
      len = len * 2;
    end
    g4[0] = 0;
    len = 1;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < len; i++) g4[2*len-1-i] = g4[i] | (1 << b);
      len = len * 2;
    end
  end

  // Model state: position in the sequence and expected overflow flag.
  int m3 = 0;
  int m4 = 0;
  bit mo3 = 1'b0;
  bit mo4 = 1'b0;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m3 = 0; m4 = 0; mo3 = 1'b0; mo4 = 1'b0;
    end else begin
`ifdef GRAY_STICKY_OVF_EN
      mo3 = mo3 | (En3 && m3 == 7);
      mo4 = mo4 | (En4 && m4 == 15);
`else
      mo3 = En3 && m3 == 7;
      mo4 = En4 && m4 == 15;
`endif
      if (En3) m3 = (m3 + 1) % 8;
      if (En4) m4 = (m4 + 1) % 16;
    end
  end

  // Per-cycle comparison against the model, including the one-bit-change rule.
  int         p3 = 0;
  int         p4 = 0;
  logic [2:0] prev3 = '0;
  logic [3:0] prev4 = '0;
  always @(negedge Clk) begin
    check("cmp_out3", 32'(out3), 32'(g3[m3]));
    check("cmp_ovf3", 32'(ovf3), 32'(mo3));
    check("cmp_out4", 32'(out4), 32'(g4[m4]));
    check("cmp_ovf4", 32'(ovf4), 32'(mo4));
    if (m3 == (p3 + 1) % 8) check("onebit3", 32'($countones(out3 ^ prev3)), 32'd1);
    if (m4 == (p4 + 1) % 16) check("onebit4", 32'($countones(out4 ^ prev4)), 32'd1);
    p3 = m3; p4 = m4; prev3 = out3; prev4 = out4;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  initial begin
    Reset = 1'b1;
    En3   = 1'b1;
    En4   = 1'b1;
    #1 Reset = 1'b0;

    cyc(10);
    check("reset_hold_out", 32'(out3), 32'd0);
    check("reset_hold_ovf", 32'(ovf3), 32'd0);
    check("table_pin", 32'(g3[4]), 32'd6);

    Reset = 1'b1;
    cyc(1);
    check("first_step", 32'(out3), 32'b001);
    cyc(7);
    check("wrap3_out", 32'(out3), 32'b000);
    check("wrap3_ovf", 32'(ovf3), 32'd1);
    check("w4_mid", 32'(out4), 32'b1100);
    cyc(7);
    check("w4_last", 32'(out4), 32'b1000);
    cyc(1);
    check("w4_wrap_out", 32'(out4), 32'b0000);
    check("w4_wrap_ovf", 32'(ovf4), 32'd1);
    check("wrap3b_ovf", 32'(ovf3), 32'd1);

    cyc(3);
    check("at_010", 32'(out3), 32'b010);
    En3 = 1'b0;
    cyc(5);
    check("hold_010", 32'(out3), 32'b010);
    En3 = 1'b1;
    cyc(1);
    check("resume_110", 32'(out3), 32'b110);
    cyc(2);
    check("at_101", 32'(out3), 32'b101);

    // Asynchronous reset in the middle of the high phase, checked before any edge.
    Reset = 1'b0;
    #1;
    check("async_out", 32'(out3), 32'd0);
    check("async_ovf", 32'(ovf3), 32'd0);
    check("async_out4", 32'(out4), 32'd0);
    cyc(1);
    Reset = 1'b1;
    cyc(1);
    check("restart_001", 32'(out3), 32'b001);

    for (int i = 0; i < 6; i++) begin
      En3 = (i % 2 == 0);
      cyc(1);
    end
    check("toggle_en", 32'(out3), 32'b110);
    En3 = 1'b1;
    cyc(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
